isochronous_src_stage: RTL
==========================

# isochronous_src_stage

Source-side feeder for the isochronous 4-phase handshake: a parameterised FIFO that accepts a stream of words and presents them on a valid/ready port with the stability guarantees the handshake requires. While out_valid_o is high and out_ready_i is low, out_valid_o and out_data_o hold their values. On every accepted transfer the block also loads a transfer data register, xfer_data_o, that holds its value until the next transfer; the destination clock domain samples it directly. The block sits in the source clock domain, directly upstream of the handshake.

## Interface
- DataWidth, 32: width of in_data_i, out_data_o and xfer_data_o.
- Depth, 2: FIFO entries. Must be >= 1 and need not be a power of two. Elaboration fails if Depth < 1.
- CntWidth, 8: width of the transfer counter xfer_count_o.
- clk_i  input  1  clock. The whole block is in the source clock domain.
- rst_i  input  1  reset. Synchronous and active-high.
- in_valid_i  input  1  upstream word valid.
- in_ready_o  output  1  block can accept a word.
- in_data_i  input  DataWidth  upstream word.
- out_valid_o  output  1  head entry valid; connects to the handshake's src_valid_i.
- out_ready_i  input  1  connects to the handshake's src_ready_o.
- out_data_o  output  DataWidth  head entry.
- xfer_data_o  output  DataWidth  last word accepted downstream; stable between transfers.
- xfer_count_o  output  CntWidth  number of downstream transfers, modulo 2^CntWidth.
- usage_o  output  $clog2(Depth+1)  current occupancy.

## Operation
- State: entry array mem_q[Depth], read pointer rptr_q, write pointer wptr_q, occupancy count_q, xfer_data_q, xfer_cnt_q.
- push = in_valid_i && in_ready_o
- pop = out_valid_o && out_ready_i
- in_ready_o = (count_q < Depth). It depends only on registered state; there is no combinational path from out_ready_i.
- out_valid_o = (count_q != 0).
- out_data_o = mem_q[rptr_q].
- usage_o = count_q.
- Push: mem_q[wptr_q] <= in_data_i. wptr_q advances, wrapping from Depth-1 to 0.
- Pop: rptr_q advances with the same wrap. xfer_data_q <= mem_q[rptr_q]. xfer_cnt_q <= xfer_cnt_q + 1, wrapping to 0 at overflow.
- Count update: count_q changes by +1 on push only, -1 on pop only, and stays the same on simultaneous push and pop.
- Simultaneous push and pop on a non-empty, non-full FIFO: both are performed and count is unchanged.
- Simultaneous push and pop when full: impossible, because in_ready_o is low when the FIFO is full.
- Empty FIFO: there is no fall-through. A word pushed into an empty FIFO appears on the output one cycle later.
- Stability: the head entry is only written when count_q == 0. Therefore out_data_o cannot change while out_valid_o is high and no pop occurs.
- Stability: out_valid_o cannot fall without a pop.
- xfer_data_o and xfer_count_o change only in the cycle after a pop.
- Reset: on any rising edge with rst_i high, the following are cleared to 0, and push and pop on that edge are ignored:
  - count_q, rptr_q, wptr_q
  - xfer_data_q, xfer_cnt_q
- mem_q is not reset.
- Reset mid-operation: buffered words are discarded, and the handshake downstream must be reset in the same cycle.

## Timing
- Output values after reset:
  - out_valid_o = 0
  - in_ready_o = 1
  - usage_o = 0
  - xfer_data_o = 0
  - xfer_count_o = 0
  - out_data_o is undefined and must not be relied on while out_valid_o = 0.
- Latency: push at edge N gives out_valid_o = 1 after edge N, when the FIFO was empty.
- Pop at edge N: xfer_data_o and xfer_count_o are updated after edge N.
- Throughput: 1 word/cycle when Depth >= 2 and out_ready_i is held high.
- Depth = 1: the block alternates between full and empty, so at most 1 word every 2 cycles enters.
- Upstream is allowed to drop in_valid_i without a push. No stability requirement is placed on the input side.

## Test plan
- Depth=2, rst_i high for 2 cycles, then low:
  - outputs are out_valid_o=0, in_ready_o=1, usage_o=0, xfer_data_o=0, xfer_count_o=0.
  - push 0xA5A5_0001 with out_ready_i=0: out_valid_o=1 and out_data_o=0xA5A5_0001 one cycle later.
- Backpressure stability: fill with 0x11 and 0x22, hold out_ready_i=0 for 10 cycles:
  - in_ready_o=0, usage_o=2, out_data_o=0x11 stable throughout.
  - further in_valid_i pulses are not accepted.
- Streaming: Depth=2, out_ready_i=1, push 0..15 back-to-back:
  - out_data_o order is 0..15 with no gaps.
  - xfer_count_o=16 and xfer_data_o=15 one cycle after the last pop.
- Wrap and non-power-of-two: Depth=3, random valid/ready for 1000 words:
  - order is preserved and usage_o never exceeds 3.
  - xfer_count_o wraps 255→0 with CntWidth=8.
- Simultaneous push/pop at usage 1: the FIFO holds one word and the next cycle has both push and pop; usage_o stays 1 and out_data_o moves to the new word.
- Reset mid-operation: rst_i for 1 cycle with usage_o=2 and in_valid_i=out_ready_i=1 on the same edge:
  - afterwards usage_o=0, out_valid_o=0, xfer_count_o=0.
  - there is no pop side-effect on xfer_data_o.

Source files
------------

// File: rtl/isochronous_src_stage.sv
// Source-side FIFO feeding the isochronous 4-phase handshake. Head data and valid stay
// stable under backpressure; every accepted transfer is captured in xfer_data_o/xfer_count_o.
module isochronous_src_stage #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth = 2,
  parameter int unsigned CntWidth = 8,
  localparam int unsigned UsageWidth = $clog2(Depth + 1),
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DataWidth-1:0]  in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DataWidth-1:0]  out_data_o,
  output logic [DataWidth-1:0]  xfer_data_o,
  output logic [CntWidth-1:0]   xfer_count_o,
  output logic [UsageWidth-1:0] usage_o
);

  if (Depth < 1) begin : gen_depth_check
    $error("isochronous_src_stage: Depth must be >= 1");
  end

  logic [DataWidth-1:0]  mem_q [Depth];
  logic [PtrWidth-1:0]   rptr_q, rptr_d;
  logic [PtrWidth-1:0]   wptr_q, wptr_d;
  logic [UsageWidth-1:0] count_q, count_d;
  logic [DataWidth-1:0]  xfer_data_q;
  logic [CntWidth-1:0]   xfer_cnt_q;
  logic                  push, pop;

  // Ready depends only on occupancy, never on out_ready_i.
  assign in_ready_o   = (count_q < UsageWidth'(Depth));
  assign out_valid_o  = (count_q != '0);
  assign out_data_o   = mem_q[rptr_q];
  assign usage_o      = count_q;
  assign xfer_data_o  = xfer_data_q;
  assign xfer_count_o = xfer_cnt_q;

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  always_comb begin
    rptr_d  = pop  ? ptr_inc(rptr_q) : rptr_q;
    wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + UsageWidth'(1);
      2'b01:   count_d = count_q - UsageWidth'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q     <= '0;
      rptr_q      <= '0;
      wptr_q      <= '0;
      xfer_data_q <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      count_q <= count_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      if (pop) begin
        xfer_data_q <= mem_q[rptr_q];
        xfer_cnt_q  <= xfer_cnt_q + CntWidth'(1);
      end
    end
  end

  // Storage has no reset; while not full wptr never aliases an occupied head entry.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_q[wptr_q] <= in_data_i;
    end
  end

endmodule
